// File: rtl/uncache_store_buffer.sv
// Posted-write buffer for uncached CPU accesses in front of the AXI uncache port.
// Stores queue in a FIFO; loads wait for every older store and stall the CPU.
module uncache_store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cpu_req,
    input  logic [3:0]  cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rvalid,
    output logic        buf_empty,
    output logic        uncache_en,
    output logic [3:0]  uncache_wen,
    output logic [31:0] uncache_addr,
    output logic [31:0] uncache_wdata,
    input  logic [31:0] uncache_rdata,
    input  logic        uncache_refresh
);

    typedef enum logic [1:0] {
        IDLE,
        WR_BUSY,
        RD_BUSY,
        RD_DONE
    } state_e;

    state_e state_q, state_d;

    logic [3:0]  fwen_q  [DEPTH];
    logic [31:0] faddr_q [DEPTH];
    logic [31:0] fdata_q [DEPTH];

    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [PTR_W:0]   cnt_q;

    logic        en_q, en_d;
    logic [3:0]  wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;

    logic full, is_store, is_load, push, pop;

    assign full     = (cnt_q == (PTR_W+1)'(DEPTH));
    assign is_store = cpu_req & (|cpu_wen);
    assign is_load  = cpu_req & ~(|cpu_wen);
    // A full FIFO refuses the store even if a pop lands this cycle.
    assign push     = is_store & ~full;

    assign cpu_stall = (is_store & full) | (is_load & ~rvalid_q);
    assign buf_empty = (cnt_q == '0) & (state_q == IDLE);

    assign cpu_rdata     = rdata_q;
    assign cpu_rvalid    = rvalid_q;
    assign uncache_en    = en_q;
    assign uncache_wen   = wen_q;
    assign uncache_addr  = addr_q;
    assign uncache_wdata = wdata_q;

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        wen_d    = wen_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        pop      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cnt_q != '0) begin
                    en_d    = 1'b1;
                    wen_d   = fwen_q[rptr_q];
                    addr_d  = faddr_q[rptr_q];
                    wdata_d = fdata_q[rptr_q];
                    state_d = WR_BUSY;
                end else if (is_load) begin
                    en_d    = 1'b1;
                    wen_d   = 4'b0000;
                    addr_d  = cpu_addr;
                    wdata_d = 32'h0;
                    state_d = RD_BUSY;
                end
            end
            WR_BUSY: begin
                if (uncache_refresh) begin
                    pop     = 1'b1;
                    en_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            RD_BUSY: begin
                if (uncache_refresh) begin
                    rdata_d  = uncache_rdata;
                    rvalid_d = 1'b1;
                    en_d     = 1'b0;
                    state_d  = RD_DONE;
                end
            end
            RD_DONE: begin
                rvalid_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            en_q     <= 1'b0;
            wen_q    <= 4'b0000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            rvalid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fwen_q[i]  <= 4'b0000;
                faddr_q[i] <= 32'h0;
                fdata_q[i] <= 32'h0;
            end
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            cnt_q    <= cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            wptr_q   <= wptr_q + PTR_W'(push);
            rptr_q   <= rptr_q + PTR_W'(pop);
            if (push) begin
                fwen_q[wptr_q]  <= cpu_wen;
                faddr_q[wptr_q] <= cpu_addr;
                fdata_q[wptr_q] <= cpu_wdata;
            end
        end
    end

endmodule
